mux_n_to_1_rr: RTL

Parametrised N-input, WIDTH-bit channel multiplexer with valid/ready handshake on every input and one registered output stage. It generalises the 3-bit 2-to-1 select mux with two select modes: explicit select, and round-robin arbitration across requesting channels. It sits between register-file/ALU sources and the 6-bit CPU's shared result bus, where several producers contend for one consumer.

---
 rtl/mux_n_to_1_rr.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mux_n_to_1_rr.sv
// N-input, WIDTH-bit channel multiplexer with valid/ready handshake, explicit-select or round-robin mode,
// and a single registered output stage. Define MUX_LOCK_EN to add the round-robin burst lock input.
module mux_n_to_1_rr #(
    parameter int WIDTH = 6,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
`ifdef MUX_LOCK_EN
    input  logic                 lock,
`endif
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_src,
    input  logic                 out_ready
);

    localparam logic [SEL_W:0]   N_EXT  = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N - 1);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_grant_vld;
    logic [SEL_W-1:0] w_grant_idx;
    logic [SEL_W:0]   w_rr_pick;
    logic [N-1:0]     w_in_ready;
    logic             w_xfer;
    logic [SEL_W-1:0] w_ptr_next;

    // Returns {found, index} of the first requester at or after ptr, wrapping at N-1.
    function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] req, input logic [SEL_W-1:0] ptr);
        logic [SEL_W:0] res;
        int             idx;
        res = '0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!res[SEL_W] && req[idx]) begin
                res = {1'b1, SEL_W'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Successor of a channel index, wrapping at the last channel.
    function automatic logic [SEL_W-1:0] idx_inc(input logic [SEL_W-1:0] idx);
        logic [SEL_W-1:0] nxt;
        if (idx == IDX_LAST) begin
            nxt = '0;
        end else begin
            nxt = idx + SEL_W'(1);
        end
        return nxt;
    endfunction

    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_ok  = ({1'b0, sel} < N_EXT);
    assign w_rr_pick = rr_pick(in_valid, r_rr_ptr);

    // Grant selection for the current mode.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (mode == 1'b0) begin
            if (w_sel_ok && in_valid[sel]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = sel;
            end else begin
                w_grant_vld = 1'b0;
            end
        end else begin
            w_grant_vld = w_rr_pick[SEL_W];
            w_grant_idx = w_rr_pick[SEL_W-1:0];
        end
    end

    // One-hot accept; nothing is accepted in reset or under backpressure.
    always_comb begin
        w_in_ready = '0;
        if (rst_n && w_load_en) begin
            if (mode == 1'b0) begin
                if (w_sel_ok) begin
                    w_in_ready[sel] = 1'b1;
                end else begin
                    w_in_ready = '0;
                end
            end else begin
                if (w_grant_vld) begin
                    w_in_ready[w_grant_idx] = 1'b1;
                end else begin
                    w_in_ready = '0;
                end
            end
        end else begin
            w_in_ready = '0;
        end
    end

    assign in_ready = w_in_ready;
    assign w_xfer   = w_grant_vld && w_load_en;

    // Pointer after a round-robin transfer; a locked burst keeps the granted channel on top.
    always_comb begin
        w_ptr_next = idx_inc(w_grant_idx);
`ifdef MUX_LOCK_EN
        if (lock) begin
            w_ptr_next = w_grant_idx;
        end else begin
            w_ptr_next = idx_inc(w_grant_idx);
        end
`endif
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_data  <= in_data[int'(w_grant_idx)*WIDTH +: WIDTH];
                r_out_src   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_ptr_next;
                end else begin
                    r_rr_ptr <= r_rr_ptr;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;

endmodule
